d_latch_checker: RTL and testbench



---
 rtl/latch_test_pkg.sv | 21 ++
 rtl/latch_ref_model.sv | 40 ++++
 rtl/d_latch_checker.sv | 138 +++++++++++++
 tb/tb_d_latch_checker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_test_pkg.sv
// Shared definitions for the D-latch stimulus generator / response checker.
package latch_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned NUM_STEPS = 6;
  localparam logic [2:0]  NO_FAIL   = 3'd7;

  // Step table entries, packed as {EN, D}.
  localparam logic [1:0] STEP0 = 2'b00;  // hold
  localparam logic [1:0] STEP1 = 2'b10;  // reset
  localparam logic [1:0] STEP2 = 2'b11;  // set
  localparam logic [1:0] STEP3 = 2'b00;  // hold
  localparam logic [1:0] STEP4 = 2'b10;  // reset
  localparam logic [1:0] STEP5 = 2'b01;  // hold

endpackage

// File: rtl/latch_ref_model.sv
// Reference model of the latch under test: tracks the expected Q once EN has
// been asserted at least once during the current run.
module latch_ref_model (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample,
  input  logic en,
  input  logic d,
  output logic exp_now,
  output logic valid_now
);

  logic exp_q;
  logic valid_q;

  // Post-update view, so the compare on the sample cycle sees this step's EN/D.
  always_comb begin
    exp_now   = exp_q;
    valid_now = valid_q;
    if (sample && en) begin
      exp_now   = d;
      valid_now = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (clear) begin
      exp_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      exp_q   <= exp_now;
      valid_q <= valid_now;
    end
  end

endmodule

// File: rtl/d_latch_checker.sv
// Plays a fixed 6-step EN/D sequence into a level-sensitive D latch and checks
// Q/Qn at the end of every step against a reference model.
module d_latch_checker
  import latch_test_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q_in,
  input  logic             qn_in,
  output logic             en_out,
  output logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_step,
  output logic [2:0]       step_idx
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0] STEP_LAST = 3'(NUM_STEPS - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             launch;
  logic             step_end;
  logic             last_step;
  logic [1:0]       cur_entry;
  logic             exp_now;
  logic             valid_now;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  function automatic logic [1:0] step_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return STEP0;
      3'd1:    return STEP1;
      3'd2:    return STEP2;
      3'd3:    return STEP3;
      3'd4:    return STEP4;
      3'd5:    return STEP5;
      default: return 2'b00;
    endcase
  endfunction

  // A run launches on a rising start seen in IDLE, so a start held high across
  // the end of a run cannot retrigger it.
  assign launch    = (state == IDLE) && start && !start_q;
  assign step_end  = (state == RUN) && (cnt == CNT_LAST);
  assign last_step = (step_idx == STEP_LAST);
  assign cur_entry = step_entry(step_idx);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  latch_ref_model u_model (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch),
    .sample    (step_end),
    .en        (cur_entry[1]),
    .d         (cur_entry[0]),
    .exp_now   (exp_now),
    .valid_now (valid_now)
  );

  assign mismatch = step_end && valid_now &&
                    ((q_in != exp_now) || (qn_in != ~exp_now));
  assign err_next = (mismatch && (err_count != '1)) ? err_count + ERR_W'(1)
                                                     : err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (step_end && last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q   <= 1'b0;
      cnt       <= '0;
      step_idx  <= '0;
      en_out    <= 1'b0;
      d_out     <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_step <= NO_FAIL;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (launch) begin
            cnt               <= '0;
            step_idx          <= '0;
            err_count         <= '0;
            pass              <= 1'b0;
            fail_step         <= NO_FAIL;
            {en_out, d_out}   <= step_entry(3'd0);
          end
        end
        RUN: begin
          if (step_end) begin
            cnt       <= '0;
            err_count <= err_next;
            if (mismatch && (fail_step == NO_FAIL)) fail_step <= step_idx;
            if (last_step) begin
              step_idx        <= '0;
              {en_out, d_out} <= 2'b00;
              pass            <= (err_next == '0);
            end else begin
              step_idx        <= step_idx + 3'd1;
              {en_out, d_out} <= step_entry(step_idx + 3'd1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_latch_checker.sv
// Bench for d_latch_checker: three instances (HOLD/ERR_W = 4/8, 1/2, 1/1) each
// driving a behavioural latch whose Q/Qn can be faulted in several ways.
module tb_d_latch_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [3];
  logic       q_v     [3];
  logic       qn_v    [3];
  logic       en_v    [3];
  logic       d_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [2:0] fail_v  [3];
  logic [2:0] step_v  [3];
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic [0:0] err_c;
  logic [2:0] lq;
  int         mode_v  [3];
  logic [5:0] mask_v  [3];

  int n_checks = 0;
  int n_fail   = 0;

  int en_tab [6] = '{0, 1, 1, 0, 1, 0};
  int d_tab  [6] = '{0, 0, 1, 0, 0, 1};

  always #5 clk = ~clk;

  d_latch_checker #(.HOLD_CYCLES(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .q_in(q_v[0]), .qn_in(qn_v[0]),
    .en_out(en_v[0]), .d_out(d_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_a), .fail_step(fail_v[0]), .step_idx(step_v[0]));

  d_latch_checker #(.HOLD_CYCLES(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .q_in(q_v[1]), .qn_in(qn_v[1]),
    .en_out(en_v[1]), .d_out(d_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_b), .fail_step(fail_v[1]), .step_idx(step_v[1]));

  d_latch_checker #(.HOLD_CYCLES(1), .ERR_W(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .q_in(q_v[2]), .qn_in(qn_v[2]),
    .en_out(en_v[2]), .d_out(d_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_c), .fail_step(fail_v[2]), .step_idx(step_v[2]));

  // Latch under test: transparent while EN is high; EN/D change only on
  // rising edges, so updating at the falling edge settles well before sampling.
  always @(negedge clk) begin
    if (rst) lq <= '0;
    else for (int i = 0; i < 3; i++) if (en_v[i]) lq[i] <= d_v[i];
  end

  // Fault modes: 0 good, 1 Q=0/Qn=1, 2 Qn=Q, 3 Q=1/Qn=0, 4 swapped, 5 Q flipped per mask step.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic mb;
      mb = (step_v[i] < 3'd6) ? mask_v[i][step_v[i]] : 1'b0;
      q_v[i]  = lq[i];
      qn_v[i] = ~lq[i];
      case (mode_v[i])
        1: begin q_v[i] = 1'b0;   qn_v[i] = 1'b1;   end
        2: begin q_v[i] = lq[i];  qn_v[i] = lq[i];  end
        3: begin q_v[i] = 1'b1;   qn_v[i] = 1'b0;   end
        4: begin q_v[i] = ~lq[i]; qn_v[i] = lq[i];  end
        5: begin q_v[i] = lq[i] ^ mb; qn_v[i] = ~lq[i]; end
        default: ;
      endcase
    end
  end

  function automatic int hold_of(int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int errmax_of(int u);
    case (u)
      0: return 255;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int get_err(int u);
    case (u)
      0: return int'(err_a);
      1: return int'(err_b);
      default: return int'(err_c);
    endcase
  endfunction

  // Expected outcome from latch semantics: Q follows D while EN, else holds.
  function automatic void model(input int u, input int mode, input logic [5:0] mask,
                                output int err, output int fs, output logic ps);
    int   cnt   = 0;
    bit   known = 0;
    bit   e     = 0;
    bit   q, qn;
    fs = 7;
    for (int s = 0; s < 6; s++) begin
      if (en_tab[s] != 0) begin
        known = 1;
        e     = (d_tab[s] != 0);
      end
      if (known) begin
        case (mode)
          1:       begin q = 0;          qn = 1;  end
          2:       begin q = e;          qn = e;  end
          3:       begin q = 1;          qn = 0;  end
          4:       begin q = !e;         qn = e;  end
          5:       begin q = e ^ mask[s]; qn = !e; end
          default: begin q = e;          qn = !e; end
        endcase
        if (q != e || qn != !e) begin
          cnt++;
          if (fs == 7) fs = s;
        end
      end
    end
    err = (cnt > errmax_of(u)) ? errmax_of(u) : cnt;
    ps  = (cnt == 0);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      n_checks++;
      if (en_v[u] !== 1'b0 || d_v[u] !== 1'b0 || busy_v[u] !== 1'b0 ||
          done_v[u] !== 1'b0 || pass_v[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl u%0d: got en=%b d=%b busy=%b done=%b pass=%b required all 0",
                 u, en_v[u], d_v[u], busy_v[u], done_v[u], pass_v[u]);
      end
      n_checks++;
      if (get_err(u) != 0 || fail_v[u] !== 3'd7 || step_v[u] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_status u%0d: got err=%0d fail=%0d step=%0d required 0/7/0",
                 u, get_err(u), fail_v[u], step_v[u]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one start and checks every cycle through a few idle cycles after done.
  task automatic run_and_check(input int u, input int mode, input logic [5:0] mask,
                               input int start_len, input int extra_at);
    int   h  = hold_of(u);
    int   t  = 6 * h + 1;
    int   xe, xf;
    logic xp;
    model(u, mode, mask, xe, xf, xp);
    mode_v[u] = mode;
    mask_v[u] = mask;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= t + 6 + start_len; k++) begin
      if (k == start_len) start_v[u] = 1'b0;
      if (k == extra_at) start_v[u] = 1'b1;
      if (k == extra_at + 1 && k > start_len) start_v[u] = 1'b0;
      n_checks++;
      if (done_v[u] !== 1'(k == t)) begin
        n_fail++;
        $display("FAIL done u%0d cycle %0d: got %b required %b", u, k, done_v[u], k == t);
      end
      n_checks++;
      if (busy_v[u] !== 1'(k < t)) begin
        n_fail++;
        $display("FAIL busy u%0d cycle %0d: got %b required %b", u, k, busy_v[u], k < t);
      end
      if (k < t) begin
        int s = (k - 1) / h;
        n_checks++;
        if (int'(step_v[u]) != s || int'(en_v[u]) != en_tab[s] || int'(d_v[u]) != d_tab[s]) begin
          n_fail++;
          $display("FAIL drive u%0d cycle %0d: got step=%0d en=%b d=%b required step=%0d en=%0d d=%0d",
                   u, k, step_v[u], en_v[u], d_v[u], s, en_tab[s], d_tab[s]);
        end
      end else begin
        n_checks++;
        if (step_v[u] !== 3'd0 || en_v[u] !== 1'b0 || d_v[u] !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_drive u%0d cycle %0d: got step=%0d en=%b d=%b required 0/0/0",
                   u, k, step_v[u], en_v[u], d_v[u]);
        end
        n_checks++;
        if (pass_v[u] !== xp || get_err(u) != xe || int'(fail_v[u]) != xf) begin
          n_fail++;
          $display("FAIL result u%0d mode%0d cycle %0d: got pass=%b err=%0d fail=%0d required pass=%b err=%0d fail=%0d",
                   u, mode, k, pass_v[u], get_err(u), fail_v[u], xp, xe, xf);
        end
      end
      @(posedge clk);
      #1;
    end
    start_v[u] = 1'b0;
    mode_v[u]  = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    for (int u = 0; u < 3; u++) run_and_check(u, 0, 6'd0, 1, 0);
  endtask

  task automatic test_stuck_q();
    run_and_check(0, 1, 6'd0, 1, 0);
    run_and_check(1, 1, 6'd0, 1, 0);
  endtask

  task automatic test_tied_qn();
    run_and_check(0, 2, 6'd0, 1, 0);
    run_and_check(2, 2, 6'd0, 1, 0);
  endtask

  task automatic test_held_start();
    run_and_check(0, 0, 6'd0, 30, 0);
  endtask

  task automatic test_back_to_back();
    run_and_check(0, 0, 6'd0, 1, 10);
    run_and_check(1, 4, 6'd0, 1, 3);
  endtask

  task automatic test_mid_reset();
    bit seen = 0;
    start_v[0] = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      if (step_v[0] == 3'd3) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reach_step3: got step=%0d required 3 within 60 cycles", step_v[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (en_v[0] !== 1'b0 || d_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 ||
        pass_v[0] !== 1'b0 || err_a !== 8'd0 || fail_v[0] !== 3'd7 || step_v[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got en=%b d=%b busy=%b done=%b pass=%b err=%0d fail=%0d step=%0d required reset values",
               en_v[0], d_v[0], busy_v[0], done_v[0], pass_v[0], err_a, fail_v[0], step_v[0]);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet cycle %0d: got done=%b busy=%b required 0/0", k, done_v[0], busy_v[0]);
      end
    end
    run_and_check(0, 0, 6'd0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int u    = $urandom_range(0, 2);
      int mode = $urandom_range(0, 5);
      int sl   = $urandom_range(1, 3);
      int xa   = ($urandom_range(0, 1) == 1) ? sl + 1 + $urandom_range(0, 2) : 0;
      logic [5:0] mask = 6'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_and_check(u, mode, mask, sl, xa);
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b0;
      mode_v[u]  = 0;
      mask_v[u]  = '0;
    end
    test_reset();
    test_nominal();
    test_stuck_q();
    test_tied_qn();
    test_held_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
